// File: rtl/arduboy_oled_pkg.sv
// arduboy_oled_pkg: shared types and constants for the SSD1306 capture path.
package arduboy_oled_pkg;
  localparam int FB_COLS = 128;
  localparam int FB_PAGES = 8;
  localparam int FB_AW = 10;
  localparam int CW = $clog2(FB_COLS);
  localparam int PW = $clog2(FB_PAGES);
  typedef enum logic [1:0] {ST_IDLE, ST_PARAM1, ST_PARAM2} state_t;
  localparam logic [7:0] OP_COL_ADDR = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
  localparam logic [7:0] OP_CONTRAST = 8'h81;
  localparam logic [7:0] OP_MEM_MODE = 8'h20;
  localparam logic [7:0] OP_MUX = 8'hA8;
  localparam logic [7:0] OP_OFFSET = 8'hD3;
  localparam logic [7:0] OP_CLKDIV = 8'hD5;
  localparam logic [7:0] OP_PRECHARGE = 8'hD9;
  localparam logic [7:0] OP_COMPINS = 8'hDA;
  localparam logic [7:0] OP_VCOMH = 8'hDB;
  localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] OP_DISP_OFF = 8'hAE;
  localparam logic [7:0] OP_DISP_ON = 8'hAF;
  localparam logic [7:0] OP_NORMAL = 8'hA6;
  localparam logic [7:0] OP_INVERSE = 8'hA7;
  function automatic logic has_param(input logic [7:0] op);
    return op inside {OP_COL_ADDR, OP_PAGE_ADDR, OP_CONTRAST, OP_MEM_MODE, OP_MUX, OP_OFFSET,
                      OP_CLKDIV, OP_PRECHARGE, OP_COMPINS, OP_VCOMH, OP_CHARGE_PUMP};
  endfunction
endpackage

// File: rtl/oled_spi_rx.sv
// oled_spi_rx: synchronizes the OLED SPI pins and assembles MSB-first bytes,
// dropping a partial byte after a long SCLK silence.
module oled_spi_rx import arduboy_oled_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       oled_clk,
  input  logic       oled_data,
  input  logic       oled_dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  logic [SYNC_STAGES-1:0] sclk_q, sclk_d, mosi_q, mosi_d, dc_q, dc_d;
  logic sclk_prev_q, sclk_prev_d, valid_q, valid_d, bdc_q, bdc_d, rise, mosi, dcs, expired;
  logic [2:0] bits_q, bits_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic [TW-1:0] idle_q, idle_d;
  always_comb begin
    sclk_d = (sclk_q << 1) | SYNC_STAGES'(oled_clk);
    mosi_d = (mosi_q << 1) | SYNC_STAGES'(oled_data);
    dc_d = (dc_q << 1) | SYNC_STAGES'(oled_dc);
    sclk_prev_d = sclk_q[SYNC_STAGES-1];
    mosi = mosi_q[SYNC_STAGES-1];
    dcs = dc_q[SYNC_STAGES-1];
    rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    expired = idle_q == TW'(IDLE_TIMEOUT - 1);
    idle_d = rise ? '0 : expired ? idle_q : idle_q + TW'(1);
    bits_d = rise ? bits_q + 3'd1 : expired ? 3'd0 : bits_q;
    shift_d = rise ? {shift_q[5:0], mosi} : shift_q;
    valid_d = rise && bits_q == 3'd7;
    byte_d = valid_d ? {shift_q, mosi} : byte_q;
    bdc_d = valid_d ? dcs : bdc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      mosi_q <= '0;
      dc_q <= '0;
      sclk_prev_q <= 1'b0;
      idle_q <= '0;
      bits_q <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      byte_q <= '0;
      bdc_q <= 1'b0;
    end else begin
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      dc_q <= dc_d;
      sclk_prev_q <= sclk_prev_d;
      idle_q <= idle_d;
      bits_q <= bits_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      byte_q <= byte_d;
      bdc_q <= bdc_d;
    end
  end
  assign byte_valid = valid_q;
  assign byte_data = byte_q;
  assign byte_dc = bdc_q;
endmodule

// File: rtl/ssd1306_capture.sv
// ssd1306_capture: snoops SSD1306 SPI traffic, decodes addressing/display commands
// and turns data bytes into framebuffer writes (horizontal addressing only).
module ssd1306_capture import arduboy_oled_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             oled_clk,
  input  logic             oled_data,
  input  logic             oled_dc,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [7:0]       fb_wdata,
  output logic             display_on,
  output logic             invert,
  output logic [7:0]       contrast
);
  logic bv, bdc;
  logic [7:0] b;
  oled_spi_rx #(.SYNC_STAGES(SYNC_STAGES), .IDLE_TIMEOUT(IDLE_TIMEOUT)) u_rx (
    .clk(clk), .rst_n(rst_n), .oled_clk(oled_clk), .oled_data(oled_data), .oled_dc(oled_dc),
    .byte_valid(bv), .byte_data(b), .byte_dc(bdc)
  );
  state_t st_q, st_d;
  logic [7:0] op_q, op_d, p1_q, p1_d, wdata_q, wdata_d, con_q, con_d;
  logic [CW-1:0] col_q, col_d, cs_q, cs_d, ce_q, ce_d;
  logic [PW-1:0] pg_q, pg_d, ps_q, ps_d, pe_q, pe_d;
  logic [FB_AW-1:0] addr_q, addr_d;
  logic we_q, we_d, on_q, on_d, inv_q, inv_d, wrap;
  always_comb begin
    st_d = st_q;
    op_d = op_q;
    p1_d = p1_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    col_d = col_q;
    pg_d = pg_q;
    cs_d = cs_q;
    ce_d = ce_q;
    ps_d = ps_q;
    pe_d = pe_q;
    on_d = on_q;
    inv_d = inv_q;
    con_d = con_q;
    wrap = col_q == ce_q;
    if (bv && bdc) begin
      st_d = ST_IDLE;
      we_d = 1'b1;
      addr_d = {pg_q, col_q};
      wdata_d = b;
      col_d = wrap ? cs_q : col_q + CW'(1);
      pg_d = !wrap ? pg_q : pg_q == pe_q ? ps_q : pg_q + PW'(1);
    end else if (bv) begin
      case (st_q)
        ST_IDLE: begin
          op_d = b;
          st_d = has_param(b) ? ST_PARAM1 : ST_IDLE;
          on_d = b == OP_DISP_ON ? 1'b1 : b == OP_DISP_OFF ? 1'b0 : on_q;
          inv_d = b == OP_INVERSE ? 1'b1 : b == OP_NORMAL ? 1'b0 : inv_q;
          col_d = b[7:4] == 4'h0 ? {col_q[6:4], b[3:0]} : b[7:3] == 5'b00010 ? {b[2:0], col_q[3:0]} : col_q;
          pg_d = b[7:3] == 5'b10110 ? b[2:0] : pg_q;
        end
        ST_PARAM1: begin
          p1_d = b;
          st_d = (op_q == OP_COL_ADDR || op_q == OP_PAGE_ADDR) ? ST_PARAM2 : ST_IDLE;
          con_d = op_q == OP_CONTRAST ? b : con_q;
        end
        ST_PARAM2: begin
          // range start is held until the end arrives so an aborted command leaves no trace
          st_d = ST_IDLE;
          cs_d = op_q == OP_COL_ADDR ? p1_q[6:0] : cs_q;
          ce_d = op_q == OP_COL_ADDR ? b[6:0] : ce_q;
          col_d = op_q == OP_COL_ADDR ? p1_q[6:0] : col_q;
          ps_d = op_q == OP_PAGE_ADDR ? p1_q[2:0] : ps_q;
          pe_d = op_q == OP_PAGE_ADDR ? b[2:0] : pe_q;
          pg_d = op_q == OP_PAGE_ADDR ? p1_q[2:0] : pg_q;
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= ST_IDLE;
      op_q <= '0;
      p1_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      col_q <= '0;
      pg_q <= '0;
      cs_q <= '0;
      ce_q <= CW'(FB_COLS - 1);
      ps_q <= '0;
      pe_q <= PW'(FB_PAGES - 1);
      on_q <= 1'b0;
      inv_q <= 1'b0;
      con_q <= 8'h7F;
    end else begin
      st_q <= st_d;
      op_q <= op_d;
      p1_q <= p1_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      col_q <= col_d;
      pg_q <= pg_d;
      cs_q <= cs_d;
      ce_q <= ce_d;
      ps_q <= ps_d;
      pe_q <= pe_d;
      on_q <= on_d;
      inv_q <= inv_d;
      con_q <= con_d;
    end
  end
  assign fb_we = we_q;
  assign fb_addr = addr_q;
  assign fb_wdata = wdata_q;
  assign display_on = on_q;
  assign invert = inv_q;
  assign contrast = con_q;
endmodule

// File: tb/tb_ssd1306_capture.sv
// tb_ssd1306_capture: table vectors, timeout/reset corner sequences and random
// traffic checked against a command-list model of the SSD1306 addressing rules.
module tb_ssd1306_capture;
  localparam int S = 2;
  localparam int TO = 64;
  logic clk = 0, rst_n = 0, oled_clk = 0, oled_data = 0, oled_dc = 0;
  logic fb_we, display_on, invert;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata, contrast;
  int checks = 0, failures = 0;
  ssd1306_capture #(.SYNC_STAGES(S), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .oled_clk(oled_clk), .oled_data(oled_data), .oled_dc(oled_dc),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .display_on(display_on), .invert(invert), .contrast(contrast)
  );
  always #5 clk = ~clk;
  int m_col, m_cs, m_ce, m_pg, m_ps, m_pe;
  logic m_on, m_inv;
  logic [7:0] m_con;
  logic [7:0] pend[$];
  typedef struct {
    logic rst;
    logic dc;
    logic [7:0] b;
    logic [9:0] ea;
    logic eon;
    logic einv;
    logic [7:0] econ;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_col = 0; m_cs = 0; m_ce = 127; m_pg = 0; m_ps = 0; m_pe = 7;
    m_on = 0; m_inv = 0; m_con = 8'h7F;
    pend.delete();
  endtask
  function automatic int need(input logic [7:0] op);
    if (op == 8'h21 || op == 8'h22) return 3;
    if (op inside {8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D}) return 2;
    return 1;
  endfunction
  task automatic m_cmd(input logic [7:0] b);
    logic [7:0] op, p1, p2;
    pend.push_back(b);
    if (pend.size() < need(pend[0])) return;
    op = pend[0];
    p1 = pend.size() > 1 ? pend[1] : 8'h00;
    p2 = pend.size() > 2 ? pend[2] : 8'h00;
    pend.delete();
    if (op == 8'h21) begin m_cs = p1 % 128; m_col = m_cs; m_ce = p2 % 128; end
    else if (op == 8'h22) begin m_ps = p1 % 8; m_pg = m_ps; m_pe = p2 % 8; end
    else if (op == 8'h81) m_con = p1;
    else if (op == 8'hAE) m_on = 0;
    else if (op == 8'hAF) m_on = 1;
    else if (op == 8'hA6) m_inv = 0;
    else if (op == 8'hA7) m_inv = 1;
    else if (op < 8'h10) m_col = (m_col / 16) * 16 + op;
    else if (op < 8'h18) m_col = (op - 16) * 16 + m_col % 16;
    else if (op >= 8'hB0 && op <= 8'hB7) m_pg = op - 8'hB0;
  endtask
  task automatic m_data(output logic [9:0] ea);
    pend.delete();
    ea = 10'(m_pg * 128 + m_col);
    if (m_col == m_ce) begin
      m_col = m_cs;
      m_pg = (m_pg == m_pe) ? m_ps : (m_pg + 1) % 8;
    end else m_col = (m_col + 1) % 128;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; oled_clk = 0; oled_data = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    model_reset();
  endtask
  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); oled_clk = 0; oled_data = 1'($urandom);
      repeat (3) @(negedge clk);
      oled_clk = 1;
      repeat (4) @(negedge clk);
    end
    oled_clk = 0;
  endtask
  task automatic send_byte(input logic dc, input logic [7:0] b, output int nwe, output int lat,
                           output logic [9:0] a, output logic [7:0] d);
    nwe = 0; lat = -1; a = '0; d = '0;
    oled_dc = dc;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); oled_clk = 0; oled_data = b[i];
      repeat (3) @(negedge clk);
      oled_clk = 1;
      if (i > 0) repeat (4) @(negedge clk);
    end
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (fb_we) begin
        nwe++;
        if (lat < 0) begin lat = c; a = fb_addr; d = fb_wdata; end
      end
    end
    @(negedge clk); oled_clk = 0;
  endtask
  task automatic do_byte(input logic dc, input logic [7:0] b, output int nwe, output int lat,
                         output logic [9:0] a, output logic [7:0] d, output logic [9:0] ea);
    ea = '0;
    if (dc) m_data(ea); else m_cmd(b);
    send_byte(dc, b, nwe, lat, a, d);
  endtask
  task automatic chk_state(input string tag, input logic eon, input logic einv, input logic [7:0] econ);
    chk({tag, " display_on"}, 32'(display_on), 32'(eon));
    chk({tag, " invert"}, 32'(invert), 32'(einv));
    chk({tag, " contrast"}, 32'(contrast), 32'(econ));
  endtask
  task automatic chk_write(input string tag, input int nwe, input int lat, input logic [9:0] a,
                           input logic [7:0] d, input logic [9:0] ea, input logic [7:0] ed);
    chk({tag, " we_count"}, 32'(nwe), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(S + 2));
    chk({tag, " addr"}, 32'(a), 32'(ea));
    chk({tag, " wdata"}, 32'(d), 32'(ed));
  endtask
  initial begin
    int nwe, lat;
    logic [9:0] a, ea;
    logic [7:0] d, b;
    logic dc;
    logic [7:0] picks[10];
    tv.push_back('{1'b1, 1'b1, 8'hA5, 10'h000, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'h21, 10'h000, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'h7E, 10'h000, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'h7F, 10'h000, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'h22, 10'h000, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'h06, 10'h000, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'h07, 10'h000, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b1, 8'h00, 10'h37E, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b1, 8'h11, 10'h37F, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b1, 8'h22, 10'h3FE, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b1, 8'h33, 10'h3FF, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b1, 8'h44, 10'h37E, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'hB3, 10'h000, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'h05, 10'h000, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'h12, 10'h000, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b1, 8'h01, 10'h1A5, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'hAF, 10'h000, 1'b1, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'hA7, 10'h000, 1'b1, 1'b1, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'h81, 10'h000, 1'b1, 1'b1, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'h40, 10'h000, 1'b1, 1'b1, 8'h40});
    tv.push_back('{1'b1, 1'b0, 8'h21, 10'h000, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b0, 8'h10, 10'h000, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b1, 8'hFF, 10'h000, 1'b0, 1'b0, 8'h7F});
    tv.push_back('{1'b0, 1'b1, 8'hEE, 10'h001, 1'b0, 1'b0, 8'h7F});
    do_reset();
    chk("reset fb_we", 32'(fb_we), 32'd0);
    chk("reset fb_addr", 32'(fb_addr), 32'd0);
    chk("reset fb_wdata", 32'(fb_wdata), 32'd0);
    chk_state("reset", 1'b0, 1'b0, 8'h7F);
    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      do_byte(tv[i].dc, tv[i].b, nwe, lat, a, d, ea);
      if (tv[i].dc) chk_write($sformatf("vec%0d", i), nwe, lat, a, d, tv[i].ea, tv[i].b);
      else chk($sformatf("vec%0d cmd_we_count", i), 32'(nwe), 32'd0);
      chk_state($sformatf("vec%0d", i), tv[i].eon, tv[i].einv, tv[i].econ);
    end
    do_reset();
    send_bits(3);
    repeat (TO + 16) @(negedge clk);
    do_byte(1'b1, 8'h3C, nwe, lat, a, d, ea);
    chk_write("idle_discard", nwe, lat, a, d, 10'h000, 8'h3C);
    do_reset();
    send_bits(3);
    do_reset();
    do_byte(1'b1, 8'h3C, nwe, lat, a, d, ea);
    chk_write("reset_discard", nwe, lat, a, d, 10'h000, 8'h3C);
    do_reset();
    for (int n = 0; n < 200; n++) begin
      picks = '{8'h21, 8'h22, 8'h81, 8'h20, 8'hAE | 8'($urandom_range(0, 1)),
                8'hA6 | 8'($urandom_range(0, 1)), 8'hB0 | 8'($urandom_range(0, 7)),
                8'($urandom_range(0, 15)), 8'h10 | 8'($urandom_range(0, 7)), 8'($urandom)};
      dc = 1'($urandom_range(0, 1));
      b = dc ? 8'($urandom) : picks[$urandom_range(0, 9)];
      do_byte(dc, b, nwe, lat, a, d, ea);
      if (dc) chk_write($sformatf("rnd%0d", n), nwe, lat, a, d, ea, b);
      else chk($sformatf("rnd%0d cmd_we_count", n), 32'(nwe), 32'd0);
      chk_state($sformatf("rnd%0d", n), m_on, m_inv, m_con);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
